// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer behind the UART receiver.
//   Frames the rx byte stream into 4-byte commands (SOF, CMD, ARG, CHK) and
//   executes valid ones against a 4-bit LED register and a blink mask.
//   Rejected frames (bad checksum, unknown command, inter-byte timeout) are
//   dropped, pulsed on frame_err, and logged in err_code / err_cnt.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  synchronous reset, active-low
//   data_rx    in   8  received byte, meaningful only while done_rx=1
//   done_rx    in   1  one-cycle strobe per received byte
//   led        out  4  led_reg ^ (blink_mask & {4{blink_phase}})
//   frame_ok   out  1  one-cycle pulse: valid frame executed
//   frame_err  out  1  one-cycle pulse: frame rejected
//   err_code   out  2  cause of last error (1 chk, 2 cmd, 3 timeout), held
//   err_cnt    out  8  rejected-frame count, saturates at 8'hFF
//
// Handshake: done_rx is a pure strobe with no back-pressure. A byte is
// transferred on every rising clk edge where done_rx=1; data_rx is ignored
// at all other times. The block always accepts, so there is no ready signal.
module uart_cmd_ctrl #(
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 5_000_000,
    parameter int         BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_rx,
    input  logic       done_rx,
    output logic [3:0] led,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] err_cnt
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BL_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_CMD = 2'd1,
        GET_ARG = 2'd2,
        GET_CHK = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      cmd_q;
    logic [7:0]      arg_q;
    logic [3:0]      led_reg;
    logic [3:0]      blink_mask;
    logic            blink_phase;
    logic [TO_W-1:0] to_cnt;
    logic [BL_W-1:0] bl_cnt;

    // Frame evaluation, decided in the cycle the byte (or the timeout) lands.
    logic [7:0] chk_sum;
    logic       chk_cycle;
    logic       chk_bad;
    logic       cmd_known;
    logic       timeout_hit;
    logic       ok_hit;
    logic       err_hit;
    logic [1:0] err_kind;

    always_comb begin
        chk_sum     = cmd_q + arg_q;
        chk_cycle   = (state == GET_CHK) && done_rx;
        chk_bad     = (data_rx != chk_sum);
        cmd_known   = (cmd_q == 8'h01) || (cmd_q == 8'h02) || (cmd_q == 8'h03);
        // A byte arriving in the expiry cycle wins over the timeout.
        timeout_hit = (state != IDLE) && !done_rx && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
        ok_hit      = chk_cycle && !chk_bad && cmd_known;
        err_hit     = timeout_hit || (chk_cycle && (chk_bad || !cmd_known));
        // Checksum takes priority over the command check.
        if (timeout_hit)  err_kind = 2'd3;
        else if (chk_bad) err_kind = 2'd1;
        else              err_kind = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            led_reg     <= 4'h0;
            blink_mask  <= 4'h0;
            blink_phase <= 1'b0;
            to_cnt      <= '0;
            bl_cnt      <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            err_cnt     <= 8'h00;
        end else begin
            // Blink timebase runs regardless of the mask.
            if (bl_cnt == BL_W'(BLINK_DIV - 1)) begin
                bl_cnt      <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bl_cnt <= bl_cnt + BL_W'(1);
            end

            // Inter-byte timeout counter, parked at zero outside a frame.
            if (state == IDLE || done_rx || timeout_hit) to_cnt <= '0;
            else                                        to_cnt <= to_cnt + TO_W'(1);

            case (state)
                IDLE:    if (done_rx && data_rx == SOF_BYTE) state <= GET_CMD;
                GET_CMD: if (done_rx) begin cmd_q <= data_rx; state <= GET_ARG; end
                GET_ARG: if (done_rx) begin arg_q <= data_rx; state <= GET_CHK; end
                GET_CHK: if (done_rx) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (timeout_hit) state <= IDLE;

            frame_ok  <= ok_hit;
            frame_err <= err_hit;

            if (ok_hit) begin
                case (cmd_q)
                    8'h01:   led_reg <= arg_q[3:0];
                    8'h02:   blink_mask <= arg_q[3:0];
                    default: begin
                        led_reg    <= 4'h0;
                        blink_mask <= 4'h0;
                    end
                endcase
            end

            if (err_hit) begin
                err_code <= err_kind;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
            end
        end
    end

    assign led = led_reg ^ (blink_mask & {4{blink_phase}});

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_rx;
    logic       done_rx;
    logic [3:0] led;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    uart_cmd_ctrl #(
        .SOF_BYTE    (8'hA5),
        .TIMEOUT_CYC (16),
        .BLINK_DIV   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_rx   (data_rx),
        .done_rx   (done_rx),
        .led       (led),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Expected pulse entry: [15:14] kind (1 ok+led, 2 err, 3 ok no led check),
    // [13:12] err_code, [11:4] err_cnt, [3:0] led.
    logic [15:0] exp_q[$];
    logic [3:0]  m_led;
    logic [7:0]  m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ok(input logic [3:0] l);
        m_led = l;
        exp_q.push_back({2'd1, 2'd0, 8'h00, l});
    endtask

    task automatic push_ok_nl();
        exp_q.push_back({2'd3, 2'd0, 8'h00, 4'h0});
    endtask

    task automatic push_err(input logic [1:0] code);
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
        exp_q.push_back({2'd2, code, m_cnt, m_led});
    endtask

    // driver tasks (called at a negedge, return at a negedge)
    task automatic send_byte(input logic [7:0] b);
        data_rx = b;
        done_rx = 1'b1;
        @(negedge clk);
        done_rx = 1'b0;
        data_rx = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && (frame_ok || frame_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_pulse: got ok=%0b err=%0b expected no pulse", frame_ok, frame_err);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("pulse_kind", {frame_ok, frame_err}, (e[15:14] == 2'd2) ? 2'b01 : 2'b10);
                if (e[15:14] == 2'd2) begin
                    check("err_code", err_code, e[13:12]);
                    check("err_cnt", err_cnt, e[11:4]);
                end
                if (e[15:14] != 2'd3) check("led_at_pulse", led, e[3:0]);
            end
        end
    end

    logic [3:0] smp[16];

    initial begin
        rst_n   = 1'b0;
        data_rx = 8'h00;
        done_rx = 1'b0;
        m_led   = 4'h0;
        m_cnt   = 8'h00;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // reset state
        check("rst_led", led, 4'h0);
        check("rst_pulses", {frame_ok, frame_err}, 2'b00);
        check("rst_err_code", err_code, 2'd0);
        check("rst_err_cnt", err_cnt, 8'h00);

        // T1 LED_SET
        push_ok(4'h5);
        send_frame(8'hA5, 8'h01, 8'h05, 8'h06);
        idle(2);

        // T2 checksum mismatch
        push_err(2'd1);
        send_frame(8'hA5, 8'h01, 8'h05, 8'h07);
        idle(2);

        // T3 unknown command with good checksum, then IDLE noise
        push_err(2'd2);
        send_frame(8'hA5, 8'h09, 8'h00, 8'h09);
        send_byte(8'h00);
        send_byte(8'hFF);
        idle(3);
        check("noise_err_cnt", err_cnt, 8'd2);

        // T4 timeout after 16 idle cycles
        push_err(2'd3);
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(20);
        check("timeout_code", err_code, 2'd3);

        // byte on the expiry cycle is consumed, no timeout
        push_ok(4'h6);
        send_byte(8'hA5);
        idle(15);
        send_byte(8'h01);
        send_byte(8'h06);
        send_byte(8'h07);
        idle(2);

        push_ok(4'h3);
        send_frame(8'hA5, 8'h01, 8'h03, 8'h04);
        idle(2);

        // T5 blink; back-to-back frames
        push_ok(4'hF);
        send_frame(8'hA5, 8'h01, 8'h0F, 8'h10);
        push_ok_nl();
        send_frame(8'hA5, 8'h02, 8'h03, 8'h05);
        idle(2);
        for (int i = 0; i < 16; i++) begin
            smp[i] = led;
            idle(1);
        end
        for (int i = 0; i < 12; i++) begin
            check("blink_value", ((smp[i] == 4'hF) || (smp[i] == 4'hC)) ? 1 : 0, 1);
            check("blink_half_period", (smp[i] != smp[i+4]) ? 1 : 0, 1);
        end

        push_ok(4'h0);
        send_frame(8'hA5, 8'h03, 8'h00, 8'h03);
        for (int i = 0; i < 8; i++) begin
            check("clr_steady", led, 4'h0);
            idle(1);
        end

        // T6 reset mid-frame
        push_ok(4'h9);
        send_frame(8'hA5, 8'h01, 8'h09, 8'h0A);
        idle(2);
        send_byte(8'hA5);
        send_byte(8'h01);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        m_led = 4'h0;
        m_cnt = 8'h00;
        idle(1);
        check("t6_led", led, 4'h0);
        check("t6_err_cnt", err_cnt, 8'h00);
        check("t6_err_code", err_code, 2'd0);

        push_ok(4'h2);
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
        idle(2);

        // saturation
        for (int i = 0; i < 256; i++) begin
            push_err(2'd1);
            send_frame(8'hA5, 8'h01, 8'h05, 8'h07);
        end
        idle(3);
        check("sat_err_cnt", err_cnt, 8'hFF);
        check("sat_led", led, 4'h2);

        // drain, bounded
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
